complex_acc_dump: RTL and testbench

COMPLEX_ACC_DUMP -- requirements
Module: complex_acc_dump

---
 rtl/complex_acc_dump.sv | 154 +++++++++++++++
 tb/tb_complex_acc_dump.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_acc_dump.sv
// Complex block accumulator: sums N=2**LOG2_LEN samples per block, then
// rounds (half up), shifts and saturates each component to OUT_WIDTH.
module complex_acc_dump #(
   parameter int unsigned IN_WIDTH  = 33,
   parameter int unsigned LOG2_LEN  = 6,
   parameter int unsigned OUT_WIDTH = 24,
   parameter int unsigned SHIFT     = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        p_valid,
   input  logic signed [IN_WIDTH-1:0]  pr,
   input  logic signed [IN_WIDTH-1:0]  pi,
   input  logic                        sync,
   output logic                        acc_valid,
   output logic signed [OUT_WIDTH-1:0] acc_r,
   output logic signed [OUT_WIDTH-1:0] acc_i,
   output logic                        ovf,
   output logic                        drop
);

   localparam int unsigned AW = IN_WIDTH + LOG2_LEN;
   localparam int unsigned CW = LOG2_LEN + 1;
   localparam logic [CW-1:0]        N_CNT   = CW'(1) << LOG2_LEN;
   localparam logic [AW:0]          RND_K   = (AW+1)'(1) << (SHIFT - 1);
   localparam logic signed [AW:0]   SAT_MAX = {{(AW+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [AW:0]   SAT_MIN = {{(AW+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
   logic signed [AW-1:0] sum_r, sum_i, sum_r_nxt, sum_i_nxt;
   logic signed [AW-1:0] add_r, add_i, ext_r, ext_i;
   logic signed [AW-1:0] dump_r, dump_i;
   logic                 dump_ld, dump_vld, drop_nxt, accept;
   logic [OUT_WIDTH:0]   rs_r_c, rs_i_c;

   // Round half up, arithmetic shift, clamp; MSB of result flags saturation
   function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [AW-1:0] d);
      logic signed [AW:0] s;
      s = $signed({d[AW-1], d}) + $signed(RND_K);
      s = s >>> SHIFT;
      if (s > SAT_MAX)
         round_sat = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
      else if (s < SAT_MIN)
         round_sat = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
      else
         round_sat = {1'b0, s[OUT_WIDTH-1:0]};
   endfunction

   // Next-state, accumulate, dump and drop decisions
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sum_r_nxt = sum_r;
      sum_i_nxt = sum_i;
      dump_ld   = 1'b0;
      drop_nxt  = 1'b0;
      accept    = 1'b0;
      ext_r     = $signed({{LOG2_LEN{pr[IN_WIDTH-1]}}, pr});
      ext_i     = $signed({{LOG2_LEN{pi[IN_WIDTH-1]}}, pi});
      // a sync sample restarts the block from zero; otherwise add to running sum
      if (p_valid && sync) begin
         add_r   = ext_r;
         add_i   = ext_i;
         cnt_inc = CW'(1);
      end else begin
         add_r   = sum_r + ext_r;
         add_i   = sum_i + ext_i;
         cnt_inc = cnt + CW'(1);
      end
      case (state)
         IDLE: begin
            if (p_valid && sync) begin
               state_nxt = ACCUM;
               accept    = 1'b1;
            end
         end
         ACCUM: begin
            if (p_valid) begin
               accept   = 1'b1;
               drop_nxt = sync && (cnt != '0);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         if (cnt_inc == N_CNT) begin
            dump_ld   = 1'b1;
            sum_r_nxt = '0;
            sum_i_nxt = '0;
            cnt_nxt   = '0;
         end else begin
            sum_r_nxt = add_r;
            sum_i_nxt = add_i;
            cnt_nxt   = cnt_inc;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Accumulators, sample count and dump stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         sum_r    <= '0;
         sum_i    <= '0;
         dump_r   <= '0;
         dump_i   <= '0;
         dump_vld <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         sum_r    <= sum_r_nxt;
         sum_i    <= sum_i_nxt;
         dump_vld <= dump_ld;
         if (dump_ld) begin
            dump_r <= add_r;
            dump_i <= add_i;
         end
      end
   end

   // Round/saturate the dumped sums
   always_comb begin
      rs_r_c = round_sat(dump_r);
      rs_i_c = round_sat(dump_i);
   end

   // Output register; results hold between dumps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_valid <= 1'b0;
         acc_r     <= '0;
         acc_i     <= '0;
         ovf       <= 1'b0;
         drop      <= 1'b0;
      end else begin
         acc_valid <= dump_vld;
         drop      <= drop_nxt;
         if (dump_vld) begin
            acc_r <= rs_r_c[OUT_WIDTH-1:0];
            acc_i <= rs_i_c[OUT_WIDTH-1:0];
            ovf   <= rs_r_c[OUT_WIDTH] | rs_i_c[OUT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_complex_acc_dump.sv
// Scoreboard bench for complex_acc_dump (IN_WIDTH=33, LOG2_LEN=2, OUT_WIDTH=24, SHIFT=8).
module tb_complex_acc_dump;

   localparam int unsigned IW = 33;
   localparam int unsigned LL = 2;
   localparam int unsigned OW = 24;
   localparam int unsigned SH = 8;
   localparam int          N  = 4;
   localparam longint      OMAX = 64'sd8388607;
   localparam longint      OMIN = -64'sd8388608;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 p_valid = 1'b0;
   logic                 sync = 1'b0;
   logic signed [IW-1:0] pr = '0;
   logic signed [IW-1:0] pi = '0;
   logic                 acc_valid;
   logic signed [OW-1:0] acc_r;
   logic signed [OW-1:0] acc_i;
   logic                 ovf;
   logic                 drop;

   complex_acc_dump #(.IN_WIDTH(IW), .LOG2_LEN(LL), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
      .clk(clk), .rst(rst), .p_valid(p_valid), .pr(pr), .pi(pi), .sync(sync),
      .acc_valid(acc_valid), .acc_r(acc_r), .acc_i(acc_i), .ovf(ovf), .drop(drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint r;
      longint i;
      longint o;
      longint cyc;
   } exp_t;

   exp_t   q[$];
   exp_t   mon_e;
   int     n_tests = 0;
   int     n_fail = 0;
   longint cyc = 0;
   bit     m_act = 0;
   int     m_cnt = 0;
   longint m_r = 0, m_i = 0;
   int     drop_exp = 0, drop_seen = 0, pulses_seen = 0;
   longint last_r = 0, last_i = 0;

   task automatic check(input string tag, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic longint rnd(input longint s);
      longint v;
      v = (s + 128) >>> 8;
      if (v > OMAX) v = OMAX;
      if (v < OMIN) v = OMIN;
      return v;
   endfunction

   function automatic longint is_sat(input longint s);
      longint v;
      v = (s + 128) >>> 8;
      return (v > OMAX || v < OMIN) ? 1 : 0;
   endfunction

   always @(posedge clk) cyc++;

   // drive one cycle of input and advance the reference model
   task automatic drive(input bit v, input bit s, input longint r, input longint i);
      exp_t e;
      @(negedge clk);
      p_valid = v;
      sync    = s;
      pr      = IW'(r);
      pi      = IW'(i);
      if (v) begin
         if (s) begin
            if (m_act && m_cnt != 0) drop_exp++;
            m_act = 1;
            m_cnt = 1;
            m_r   = r;
            m_i   = i;
         end else if (m_act) begin
            m_cnt++;
            m_r += r;
            m_i += i;
         end
         if (m_act && m_cnt == N) begin
            e.r   = rnd(m_r);
            e.i   = rnd(m_i);
            e.o   = is_sat(m_r) | is_sat(m_i);
            e.cyc = cyc + 2;
            q.push_back(e);
            m_r   = 0;
            m_i   = 0;
            m_cnt = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   task automatic block(input bit s, input longint r, input longint i);
      for (int k = 0; k < N; k++) drive(1, s && (k == 0), r, i);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #2;
      rst     = 1'b1;
      p_valid = 1'b0;
      sync    = 1'b0;
      q.delete();
      m_act = 0;
      m_cnt = 0;
      m_r   = 0;
      m_i   = 0;
      #1;
      check("rst_valid", acc_valid, 0);
      check("rst_acc_r", acc_r, 0);
      check("rst_acc_i", acc_i, 0);
      check("rst_ovf", ovf, 0);
      check("rst_drop", drop, 0);
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // monitor: pop expected result on every acc_valid pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (drop) drop_seen++;
         if (acc_valid) begin
            pulses_seen++;
            if (q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               mon_e = q.pop_front();
               check("acc_r", acc_r, mon_e.r);
               check("acc_i", acc_i, mon_e.i);
               check("ovf", ovf, mon_e.o);
               check("latency_cycle", cyc, mon_e.cyc);
               last_r = mon_e.r;
               last_i = mon_e.i;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      longint a, b;
      do_reset(3);
      // samples without sync after reset are ignored
      drive(1, 0, 5, 5); drive(1, 0, 5, 5); drive(1, 0, 5, 5); drive(1, 0, 5, 5);
      idle(4);
      block(1, 100, -100);
      idle(3);
      block(1, 96, -96);
      idle(3);
      block(1, 64'sd2147483648, -64'sd4294967296);
      idle(3);
      // partial block discarded by sync
      drive(1, 1, 256, 0); drive(1, 0, 256, 0);
      block(1, 256, 0);
      idle(4);
      check("drop_count_partial", drop_seen, 1);
      // three blocks with random gaps; only the first carries sync
      p0 = pulses_seen;
      for (int bk = 0; bk < 3; bk++) begin
         for (int k = 0; k < N; k++) begin
            while ($urandom_range(0, 2) == 0) drive(0, 0, 0, 0);
            a = longint'($signed($urandom));
            b = longint'($signed($urandom));
            if ($urandom_range(0, 1) == 1) begin a = a * 2; b = b % 1000; end
            drive(1, (bk == 0) && (k == 0), a, b);
         end
      end
      idle(4);
      check("random_pulses", pulses_seen - p0, 3);
      // full rate: sync right after a completed block, then a no-sync block
      p0 = pulses_seen;
      block(1, 1000, 2000);
      block(1, -3000, 77);
      block(0, 123456, -654321);
      idle(4);
      check("fullrate_pulses", pulses_seen - p0, 3);
      check("drop_count_total", drop_seen, drop_exp);
      // reset with a dump in flight
      block(1, 500, 500);
      do_reset(2);
      idle(4);
      block(0, 700, 700);
      idle(4);
      // reset mid-block
      drive(1, 1, 900, 900); drive(1, 0, 900, 900);
      do_reset(1);
      idle(3);
      block(1, -1000, 1000);
      idle(4);
      check("queue_empty", q.size(), 0);
      check("hold_acc_r", acc_r, last_r);
      check("hold_acc_i", acc_i, last_i);
      check("drop_count_final", drop_seen, drop_exp);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
